// File: rtl/maquina_cafe_pkg.sv
// Shared definitions for the coffee-machine blocks: FSM states, coin values,
// default coin-total limit and product prices.
package maquina_cafe_pkg;

  typedef enum logic [1:0] {
    INACTIVO   = 2'd0,
    ACUMULANDO = 2'd1,
    ENTREGA    = 2'd2,
    DEVOLUCION = 2'd3
  } estado_t;

  localparam logic [3:0] VAL_M1 = 4'd1;
  localparam logic [3:0] VAL_M2 = 4'd2;
  localparam logic [3:0] VAL_M5 = 4'd5;

  localparam int MAX_ACUM_DEF = 15;
  localparam int NUM_ENTRADAS = 5;

  localparam logic [3:0] PRECIO_0 = 4'd3;
  localparam logic [3:0] PRECIO_1 = 4'd4;
  localparam logic [3:0] PRECIO_2 = 4'd5;
  localparam logic [3:0] PRECIO_3 = 4'd7;

  // Field order matches the synchronizer pulse vector, LSB = moneda_1.
  typedef struct packed {
    logic cancelar;
    logic pedido;
    logic m5;
    logic m2;
    logic m1;
  } eventos_t;

  function automatic logic [4:0] suma_monedas(input eventos_t e);
    logic [4:0] s;
    s = 5'd0;
    if (e.m1) s = s + 5'(VAL_M1);
    if (e.m2) s = s + 5'(VAL_M2);
    if (e.m5) s = s + 5'(VAL_M5);
    return s;
  endfunction

endpackage

// File: rtl/sincronizador_flanco.sv
// Two-flop synchronizer plus rising-edge detector producing a one-cycle pulse.
// An input already high when reset is released must go low before it can fire.
module sincronizador_flanco (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulso
);

  logic       s1, s2, s3, armado;
  logic [1:0] vld_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      armado   <= 1'b0;
      vld_pipe <= '0;
    end else begin
      s1       <= din;
      s2       <= s1;
      s3       <= s2;
      vld_pipe <= {vld_pipe[0], 1'b1};
      // s2 only reflects the real input once two samples have shifted in
      if (vld_pipe[1] && !s2) armado <= 1'b1;
    end
  end

  assign pulso = s2 & ~s3 & armado;

endmodule

// File: rtl/acumulador_monedas.sv
// Coin accumulator: synchronizes the coin/button inputs, keeps the saturating
// coin total and sequences dispense / refund holds.
module acumulador_monedas
  import maquina_cafe_pkg::*;
#(
  parameter int T_ENTREGA = 50_000_000,
  parameter int MAX_ACUM  = MAX_ACUM_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       moneda_1,
  input  logic       moneda_2,
  input  logic       moneda_5,
  input  logic       pedido,
  input  logic       cancelar,
  input  logic       aceptada,
  output logic [3:0] Acumulador_Monedas,
  output logic       dispensar,
  output logic       devolver,
  output logic [3:0] monto_devuelto,
  output logic       moneda_rechazada
);

  localparam int         CW     = (T_ENTREGA > 1) ? $clog2(T_ENTREGA) : 1;
  localparam logic [CW-1:0] FIN = CW'(T_ENTREGA - 1);
  localparam logic [4:0] LIMITE = 5'(MAX_ACUM);

  logic [NUM_ENTRADAS-1:0] crudo, pulso;
  eventos_t                ev;
  estado_t                 estado;
  logic [CW-1:0]           cnt;
  logic [4:0]              suma, tot_ext;
  logic                    hay_moneda;

  assign crudo = {cancelar, pedido, moneda_5, moneda_2, moneda_1};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENTRADAS; gi++) begin : g_sync
      sincronizador_flanco u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (crudo[gi]),
        .pulso (pulso[gi])
      );
    end
  endgenerate

  assign ev         = eventos_t'(pulso);
  assign suma       = suma_monedas(ev);
  assign tot_ext    = {1'b0, Acumulador_Monedas} + suma;
  assign hay_moneda = ev.m1 | ev.m2 | ev.m5;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado             <= INACTIVO;
      Acumulador_Monedas <= '0;
      dispensar          <= 1'b0;
      devolver           <= 1'b0;
      monto_devuelto     <= '0;
      moneda_rechazada   <= 1'b0;
      cnt                <= '0;
    end else begin
      moneda_rechazada <= 1'b0;
      unique case (estado)
        INACTIVO, ACUMULANDO: begin
          // Cancel beats an order; coins arriving with either are refused
          if (estado == ACUMULANDO && ev.cancelar) begin
            estado             <= DEVOLUCION;
            monto_devuelto     <= Acumulador_Monedas;
            Acumulador_Monedas <= '0;
            devolver           <= 1'b1;
            cnt                <= '0;
            moneda_rechazada   <= hay_moneda;
          end else if (estado == ACUMULANDO && ev.pedido && aceptada) begin
            estado           <= ENTREGA;
            dispensar        <= 1'b1;
            cnt              <= '0;
            moneda_rechazada <= hay_moneda;
          end else if (hay_moneda) begin
            if (tot_ext <= LIMITE) begin
              Acumulador_Monedas <= tot_ext[3:0];
              estado             <= ACUMULANDO;
            end else begin
              moneda_rechazada <= 1'b1;
            end
          end
        end
        ENTREGA: begin
          moneda_rechazada <= hay_moneda;
          if (cnt == FIN) begin
            estado             <= INACTIVO;
            dispensar          <= 1'b0;
            Acumulador_Monedas <= '0;
            cnt                <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DEVOLUCION: begin
          moneda_rechazada <= hay_moneda;
          if (cnt == FIN) begin
            estado         <= INACTIVO;
            devolver       <= 1'b0;
            monto_devuelto <= '0;
            cnt            <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: estado <= INACTIVO;
      endcase
    end
  end

endmodule

// File: tb/tb_acumulador_monedas.sv
// Directed plus randomized bench for acumulador_monedas against a
// transaction-level model of the coin total.
module tb_acumulador_monedas;

  localparam int T    = 8;
  localparam int MAXA = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       moneda_1 = 1'b0, moneda_2 = 1'b0, moneda_5 = 1'b0;
  logic       pedido = 1'b0, cancelar = 1'b0, aceptada = 1'b0;
  logic [3:0] Acumulador_Monedas, monto_devuelto;
  logic       dispensar, devolver, moneda_rechazada;

  int tests = 0, fails = 0;
  int total = 0;
  int rej_cnt = 0, disp_cycles = 0, dev_cycles = 0;

  acumulador_monedas #(.T_ENTREGA(T), .MAX_ACUM(MAXA)) dut (
    .clk(clk), .rst_n(rst_n),
    .moneda_1(moneda_1), .moneda_2(moneda_2), .moneda_5(moneda_5),
    .pedido(pedido), .cancelar(cancelar), .aceptada(aceptada),
    .Acumulador_Monedas(Acumulador_Monedas), .dispensar(dispensar),
    .devolver(devolver), .monto_devuelto(monto_devuelto),
    .moneda_rechazada(moneda_rechazada)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (moneda_rechazada === 1'b1) rej_cnt++;
    if (dispensar === 1'b1) disp_cycles++;
    if (devolver === 1'b1) dev_cycles++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One press of the given inputs, then the reference outcome is checked.
  task automatic op(input logic [2:0] mc, input logic p, input logic c,
                    input logic acc, input logic coin_in_hold, input string tag);
    int  s, r0, d0, v0, exp_rej, nuevo;
    bit  ent, dev;
    s   = (mc[0] ? 1 : 0) + (mc[1] ? 2 : 0) + (mc[2] ? 5 : 0);
    dev = c && total != 0;
    ent = !dev && p && acc && total != 0;
    exp_rej = (mc != 0 && (dev || ent || total + s > MAXA)) ? 1 : 0;
    nuevo = (mc != 0 && exp_rej == 0) ? total + s : total;
    r0 = rej_cnt; d0 = disp_cycles; v0 = dev_cycles;
    @(negedge clk);
    moneda_1 = mc[0]; moneda_2 = mc[1]; moneda_5 = mc[2];
    pedido = p; cancelar = c; aceptada = acc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    moneda_1 = 0; moneda_2 = 0; moneda_5 = 0; pedido = 0; cancelar = 0; aceptada = 0;
    repeat (2) @(negedge clk);
    chk({tag, " rej"}, rej_cnt - r0, exp_rej);
    if (ent) begin
      chk({tag, " dispensar"}, dispensar, 1);
      chk({tag, " total hold"}, Acumulador_Monedas, total);
      if (coin_in_hold) begin
        moneda_2 = 1; @(negedge clk); moneda_2 = 0;
        repeat (3) @(negedge clk);
        chk({tag, " rej in hold"}, rej_cnt - r0, 1);
        chk({tag, " total in hold"}, Acumulador_Monedas, total);
      end
    end else if (dev) begin
      chk({tag, " devolver"}, devolver, 1);
      chk({tag, " monto"}, monto_devuelto, total);
      chk({tag, " total refund"}, Acumulador_Monedas, 0);
    end else begin
      chk({tag, " total"}, Acumulador_Monedas, nuevo);
      chk({tag, " idle outs"}, {dispensar, devolver}, 0);
    end
    if (ent || dev) begin
      repeat (T + 2) @(negedge clk);
      chk({tag, " after total"}, Acumulador_Monedas, 0);
      chk({tag, " after outs"}, {dispensar, devolver, monto_devuelto}, 0);
      chk({tag, " hold len"}, ent ? disp_cycles - d0 : dev_cycles - v0, T);
      total = 0;
    end else begin
      total = nuevo;
    end
    @(negedge clk);
  endtask

  initial begin
    int r0;
    logic [2:0] mc;
    #1;
    chk("reset total", Acumulador_Monedas, 0);
    chk("reset outs", {dispensar, devolver, moneda_rechazada}, 0);
    chk("reset monto", monto_devuelto, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);

    // Coin latency: total changes on the third edge after the input is seen high
    moneda_1 = 1;
    @(posedge clk); @(posedge clk); #1;
    chk("latency edge2", Acumulador_Monedas, 0);
    @(posedge clk); #1;
    chk("latency edge3", Acumulador_Monedas, 1);
    @(negedge clk); moneda_1 = 0;
    repeat (3) @(negedge clk);
    total = 1;
    op(3'b000, 0, 1, 0, 0, "cancel one");

    op(3'b000, 1, 1, 1, 0, "idle buttons");
    op(3'b010, 0, 0, 0, 0, "m2 a");
    op(3'b010, 0, 0, 0, 0, "m2 b");
    op(3'b000, 1, 0, 1, 1, "order 4");
    op(3'b100, 0, 0, 0, 0, "m5 a");
    op(3'b100, 0, 0, 0, 0, "m5 b");
    op(3'b100, 0, 0, 0, 0, "m5 c");
    op(3'b001, 0, 0, 0, 0, "m1 at 15");
    op(3'b000, 0, 1, 0, 0, "cancel 15");
    op(3'b100, 0, 0, 0, 0, "m5");
    op(3'b001, 0, 0, 0, 0, "m1");
    op(3'b000, 0, 1, 0, 0, "cancel 6");
    op(3'b010, 0, 0, 0, 0, "m2");
    op(3'b000, 1, 0, 0, 0, "order refused");
    op(3'b000, 0, 1, 0, 0, "cancel 2");
    op(3'b100, 0, 0, 0, 0, "m5 x");
    op(3'b100, 0, 0, 0, 0, "m5 y");
    op(3'b101, 0, 0, 0, 0, "batch at 10");
    op(3'b000, 0, 1, 0, 0, "cancel 10");
    op(3'b100, 0, 0, 0, 0, "m5 z");
    op(3'b011, 0, 0, 0, 0, "m2m1");
    op(3'b101, 0, 0, 0, 0, "batch at 8");
    op(3'b000, 0, 1, 0, 0, "cancel 14");
    op(3'b011, 0, 0, 0, 0, "m3");
    op(3'b001, 1, 1, 1, 0, "cancel wins");

    for (int i = 0; i < 60; i++) begin
      int k;
      k  = $urandom_range(0, 9);
      mc = 3'($urandom_range(0, 7));
      if (k < 6) op((mc == 0) ? 3'b001 : mc, 0, 0, 0, 0, "rnd coin");
      else if (k < 8) op(($urandom_range(0, 3) == 0) ? mc : 3'b000, 1, 0, 1'($urandom_range(0, 1)), 0, "rnd order");
      else if (k == 8) op(3'b000, 0, 1, 0, 0, "rnd cancel");
      else op(mc, 1, 1, 1, 0, "rnd both");
    end
    if (total != 0) op(3'b000, 0, 1, 0, 0, "rnd flush");

    // Reset in the middle of a dispense of 7
    op(3'b100, 0, 0, 0, 0, "rst m5");
    op(3'b010, 0, 0, 0, 0, "rst m2");
    @(negedge clk);
    pedido = 1; aceptada = 1;
    repeat (3) @(posedge clk);
    @(negedge clk); pedido = 0; aceptada = 0;
    repeat (2) @(negedge clk);
    chk("rst pre dispensar", dispensar, 1);
    #2 rst_n = 0;
    #1;
    chk("rst async total", Acumulador_Monedas, 0);
    chk("rst async outs", {dispensar, devolver, moneda_rechazada, monto_devuelto}, 0);
    total = 0;
    @(negedge clk); rst_n = 1;
    repeat (T + 3) @(negedge clk);
    chk("rst post outs", {dispensar, Acumulador_Monedas}, 0);
    op(3'b001, 0, 0, 0, 0, "rst post m1");
    op(3'b000, 0, 1, 0, 0, "rst post cancel");

    // Coin slot held high across reset release
    r0 = rej_cnt;
    @(negedge clk); moneda_5 = 1;
    repeat (2) @(negedge clk); rst_n = 0;
    repeat (2) @(negedge clk); rst_n = 1;
    repeat (8) @(negedge clk);
    chk("held total", Acumulador_Monedas, 0);
    chk("held rej", rej_cnt - r0, 0);
    moneda_5 = 0;
    repeat (4) @(negedge clk);
    op(3'b100, 0, 0, 0, 0, "held repress");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
